// File: rtl/irq_controller.sv
// Interrupt controller: latches source pulses into a W1C active register, masks them
// with per-source enables, and presents the highest-priority request to the CPU.
module irq_controller #(
  parameter logic [23:0] IRQ_PRI = 24'h2020,
  parameter logic [23:0] IRQ_ENA = 24'h2023,
  parameter logic [23:0] IRQ_ACT = 24'h2027
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic [31:0] irq_in,
  output logic        irq_req,
  output logic [4:0]  irq_vector,
  output logic [1:0]  irq_level
);

  logic [31:0] r_act;
  logic [31:0] r_ena;
  logic [15:0] r_pri;
  logic        r_req;
  logic [4:0]  r_vector;
  logic [1:0]  r_level;

  logic [23:0] w_off_pri;
  logic [23:0] w_off_ena;
  logic [23:0] w_off_act;
  logic        w_hit_pri;
  logic        w_hit_ena;
  logic        w_hit_act;
  logic [31:0] w_act_clr;
  logic [3:0]  w_ena_we;
  logic [1:0]  w_pri_we;
  logic [1:0]  w_best_lvl;
  logic [4:0]  w_best_vec;
  logic        w_unused;

  // Reads have no side effects, so the strobe carries no information here.
  assign w_unused = bus_read;

  assign w_off_pri = bus_address_in - IRQ_PRI;
  assign w_off_ena = bus_address_in - IRQ_ENA;
  assign w_off_act = bus_address_in - IRQ_ACT;
  assign w_hit_pri = (w_off_pri < 24'd2);
  assign w_hit_ena = (w_off_ena < 24'd4);
  assign w_hit_act = (w_off_act < 24'd4);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    bus_data_out = 8'h00;
    if (w_hit_pri)      bus_data_out = r_pri[{w_off_pri[0], 3'b000} +: 8];
    else if (w_hit_ena) bus_data_out = r_ena[{w_off_ena[1:0], 3'b000} +: 8];
    else if (w_hit_act) bus_data_out = r_act[{w_off_act[1:0], 3'b000} +: 8];
  end

  always_comb begin
    w_act_clr = '0;
    w_ena_we  = '0;
    w_pri_we  = '0;
    if (bus_write) begin
      if (w_hit_act) w_act_clr[{w_off_act[1:0], 3'b000} +: 8] = bus_data_in;
      if (w_hit_ena) w_ena_we[w_off_ena[1:0]] = 1'b1;
      if (w_hit_pri) w_pri_we[w_off_pri[0]]   = 1'b1;
    end
  end

  // Strict '>' over ascending index keeps the lowest index on a level tie; level 0 never wins.
  always_comb begin
    w_best_lvl = 2'd0;
    w_best_vec = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (r_act[i] && r_ena[i] && (r_pri[2*(i/4) +: 2] > w_best_lvl)) begin
        w_best_lvl = r_pri[2*(i/4) +: 2];
        w_best_vec = 5'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act    <= '0;
      r_ena    <= '0;
      r_pri    <= '0;
      r_req    <= 1'b0;
      r_vector <= '0;
      r_level  <= '0;
    end else if (clk_ce) begin
      // Set is OR-ed in after the clear so a same-cycle pulse survives.
      r_act <= (r_act & ~w_act_clr) | irq_in;
      for (int k = 0; k < 4; k++)
        if (w_ena_we[k]) r_ena[8*k +: 8] <= bus_data_in;
      for (int k = 0; k < 2; k++)
        if (w_pri_we[k]) r_pri[8*k +: 8] <= bus_data_in;
      r_req    <= (w_best_lvl != 2'd0);
      r_vector <= w_best_vec;
      r_level  <= w_best_lvl;
    end
  end

  assign irq_req    = r_req;
  assign irq_vector = r_vector;
  assign irq_level  = r_level;

endmodule
